seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 19 +
 rtl/bin2bcd_seq.sv | 66 ++++++
 rtl/seg_scan_driver.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package seg_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} conv_state_t;

   localparam int unsigned DIGITS_DEC = 5;
   localparam int unsigned DIGITS_HEX = 4;

   // Active-low {dp, g, f, e, d, c, b, a}; entry 15 first so index n holds the code for n.
   localparam logic [15:0][7:0] SEG_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   function automatic logic [7:0] seg_decode(input logic [3:0] nib);
      return SEG_TABLE[nib];
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (double dabble, one bit per cycle).
module bin2bcd_seq
   import seg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] bin,
   output logic [19:0] bcd,
   output logic        busy,
   output logic        done
);

   conv_state_t state_q;
   logic [15:0] op_q;
   logic [19:0] acc_q;
   logic [19:0] acc_adj;
   logic [3:0]  iter_q;

   // Add 3 to every BCD nibble that is 5 or more ahead of the shift.
   always_comb begin
      acc_adj = acc_q;
      for (int unsigned i = 0; i < 5; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Conversion FSM; bin must stay stable from start until done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         acc_q   <= '0;
         iter_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) state_q <= LOAD;
            end
            LOAD: begin
               acc_q   <= '0;
               op_q    <= bin;
               iter_q  <= '0;
               state_q <= SHIFT;
            end
            SHIFT: begin
               acc_q  <= {acc_adj[18:0], op_q[15]};
               op_q   <= {op_q[14:0], 1'b0};
               iter_q <= iter_q + 4'd1;
               if (iter_q == 4'd15) state_q <= COMMIT;
            end
            COMMIT: begin
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bcd  = acc_q;
   assign busy = (state_q != IDLE);
   assign done = (state_q == COMMIT);

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit seven-segment driver showing a 16-bit value in decimal or hex.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 100000,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] result,
   input  logic        mode_hex,
   output logic [7:0]  an,
   output logic [7:0]  seg,
   output logic        busy
);

   localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [15:0]   shadow_val_q;
   logic          shadow_hex_q;
   logic [15:0]   last_val_q;
   logic          last_hex_q;
   logic [19:0]   disp_q;
   logic          disp_hex_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    idx_q;
   logic [7:0]    an_q;
   logic [7:0]    seg_q;

   logic          start;
   logic          conv_busy;
   logic          conv_done;
   logic [19:0]   conv_bcd;

   assign start = !conv_busy && ({result, mode_hex} != {last_val_q, last_hex_q});

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (shadow_val_q),
      .bcd   (conv_bcd),
      .busy  (conv_busy),
      .done  (conv_done)
   );

   // Shadow/last-converted pair and display register; hex bypasses BCD but commits on the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_val_q <= '0;
         shadow_hex_q <= 1'b0;
         last_val_q   <= '0;
         last_hex_q   <= 1'b0;
         disp_q       <= '0;
         disp_hex_q   <= 1'b0;
      end else begin
         if (!conv_busy) begin
            shadow_val_q <= result;
            shadow_hex_q <= mode_hex;
         end
         if (start) begin
            last_val_q <= result;
            last_hex_q <= mode_hex;
         end
         if (conv_done) begin
            disp_q     <= shadow_hex_q ? {4'h0, shadow_val_q} : conv_bcd;
            disp_hex_q <= shadow_hex_q;
         end
      end
   end

   // Digit dwell counter and digit index, both free-running with wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else if (cnt_q == CW'(SCAN_DIV - 1)) begin
         cnt_q <= '0;
         idx_q <= idx_q + 3'd1;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   logic [2:0]  ndig;
   logic [2:0]  msd;
   logic [31:0] disp_ext;
   logic [3:0]  nib;
   logic [7:0]  an_d;
   logic [7:0]  seg_d;

   // Select the current digit, find the most significant nonzero digit, and decode.
   always_comb begin
      ndig     = disp_hex_q ? 3'(DIGITS_HEX) : 3'(DIGITS_DEC);
      msd      = 3'd0;
      disp_ext = {12'h000, disp_q};
      for (int unsigned i = 0; i < DIGITS_DEC; i++) begin
         if ((disp_q[4*i +: 4] != 4'h0) && (3'(i) < ndig)) msd = 3'(i);
      end
      nib   = disp_ext[{idx_q, 2'b00} +: 4];
      an_d  = 8'hFF;
      seg_d = 8'hFF;
      if (idx_q < ndig) begin
         an_d[idx_q] = 1'b0;
         // Blanked leading zeros keep the anode on but light no segments.
         if (!(BLANK_LZ && (idx_q > msd))) seg_d = seg_decode(nib);
      end
   end

   // Registered anode/cathode outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_q  <= 8'hFF;
         seg_q <= 8'hFF;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign an   = an_q;
   assign seg  = seg_q;
   assign busy = conv_busy;

endmodule
